// File: rtl/traffic_ctrl_nphase_if.sv
`default_nettype none
// ============================================================================
// Module   : traffic_ctrl_nphase_if
// Brief    : Sensor/lamp bundle of the N-approach intersection controller.
// Revision : 1.0
// ============================================================================
interface traffic_ctrl_nphase_if #(
    parameter int NUM_APPR = 2
);
    logic [NUM_APPR-1:0]   sense;
    logic [3*NUM_APPR-1:0] light;
    logic [1:0]            cur_appr;
    logic [1:0]            phase;

    modport master (output sense, input light, input cur_appr, input phase);
    modport slave  (input sense, output light, output cur_appr, output phase);
endinterface
`default_nettype wire

// File: rtl/traffic_ctrl_nphase.sv
`default_nettype none
// ============================================================================
// Module   : traffic_ctrl_nphase
// Brief    : N-approach sensor-driven intersection controller, main road rests
//            green; optional all-red clearance enabled by TRAFFIC_ALLRED_EN.
// Revision : 1.0
// ============================================================================
module traffic_ctrl_nphase #(
    parameter int NUM_APPR    = 2,
    parameter int CLK_HZ      = 50000000,
    parameter int GREEN_MIN_S = 10,
    parameter int GREEN_MAX_S = 20,
    parameter int YELLOW_S    = 3,
    parameter int ALLRED_S    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    traffic_ctrl_nphase_if.slave bus
);

    localparam int PRESC_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int SEC_W   = $clog2(GREEN_MAX_S + YELLOW_S + ALLRED_S + 2);
    localparam logic [PRESC_W-1:0]    PRESC_TERM = PRESC_W'(CLK_HZ - 1);
    localparam logic [SEC_W-1:0]      SEC_SAT    = '1;
    localparam logic [3*NUM_APPR-1:0] LIGHT_RST  = {{(NUM_APPR-1){3'b100}}, 3'b001};

    typedef enum logic [1:0] {
        ST_GREEN  = 2'b00,
        ST_YELLOW = 2'b01,
        ST_ALLRED = 2'b10
    } state_t;

    state_t                state_q,    state_d;
    logic [1:0]            cur_appr_q, cur_appr_d;
    logic [1:0]            nxt_appr_q, nxt_appr_d;
    logic [NUM_APPR-1:0]   demand_q,   demand_d;
    logic [PRESC_W-1:0]    presc_q,    presc_d;
    logic [SEC_W-1:0]      sec_q,      sec_d;
    logic [3*NUM_APPR-1:0] light_q,    light_d;
    logic [1:0]            phase_q,    phase_d;

    logic tick;
    logic cur_sense;
    int   sec_inc;

    // Round-robin: first pending approach above 'from', otherwise the main road.
    function automatic logic [1:0] f_scan(input logic [1:0] from, input logic [NUM_APPR-1:0] dem);
        logic found;
        f_scan = 2'd0;
        found  = 1'b0;
        for (int j = 1; j < NUM_APPR; j++) begin
            if (!found && (2'(j) > from) && dem[j]) begin
                f_scan = 2'(j);
                found  = 1'b1;
            end
        end
    endfunction

    assign tick    = (presc_q == PRESC_TERM);
    assign sec_inc = int'(sec_q) + 1;

    always_comb begin
        cur_sense = 1'b0;
        for (int j = 1; j < NUM_APPR; j++) begin
            if (cur_appr_q == 2'(j)) cur_sense = bus.sense[j];
        end
    end

    always_comb begin
        state_d    = state_q;
        cur_appr_d = cur_appr_q;
        nxt_appr_d = nxt_appr_q;
        case (state_q)
            ST_GREEN: begin
                if (tick && (sec_inc >= GREEN_MIN_S)) begin
                    if ((cur_appr_q == 2'd0) ? (|demand_q)
                                             : (!cur_sense || (sec_inc >= GREEN_MAX_S))) begin
                        state_d    = ST_YELLOW;
                        nxt_appr_d = f_scan(cur_appr_q, demand_q);
                    end
                end
            end
            ST_YELLOW: begin
                if (tick && (sec_inc == YELLOW_S)) begin
`ifdef TRAFFIC_ALLRED_EN
                    state_d    = ST_ALLRED;
`else
                    state_d    = ST_GREEN;
                    cur_appr_d = nxt_appr_q;
`endif
                end
            end
`ifdef TRAFFIC_ALLRED_EN
            ST_ALLRED: begin
                if (tick && (sec_inc == ALLRED_S)) begin
                    state_d    = ST_GREEN;
                    cur_appr_d = nxt_appr_q;
                end
            end
`endif
            default: begin
                state_d    = ST_GREEN;
                cur_appr_d = 2'd0;
            end
        endcase
    end

    // Every interval restarts from zero on a state change so it spans whole seconds.
    always_comb begin
        presc_d = presc_q;
        sec_d   = sec_q;
        if (state_d != state_q) begin
            presc_d = '0;
            sec_d   = '0;
        end else if (tick) begin
            presc_d = '0;
            sec_d   = (sec_q == SEC_SAT) ? sec_q : sec_q + 1'b1;
        end else begin
            presc_d = presc_q + 1'b1;
        end
    end

    always_comb begin
        demand_d    = demand_q;
        demand_d[0] = 1'b0;
        for (int j = 1; j < NUM_APPR; j++) begin
            if ((state_d == ST_GREEN) && (state_q != ST_GREEN) && (cur_appr_d == 2'(j))) begin
                demand_d[j] = 1'b0;
            end else if (bus.sense[j] && !((state_q == ST_GREEN) && (cur_appr_q == 2'(j)))) begin
                demand_d[j] = 1'b1;
            end
        end
    end

    always_comb begin
        light_d = '0;
        for (int j = 0; j < NUM_APPR; j++) begin
            light_d[3*j +: 3] = 3'b100;
            if (cur_appr_d == 2'(j)) begin
                if (state_d == ST_GREEN)       light_d[3*j +: 3] = 3'b001;
                else if (state_d == ST_YELLOW) light_d[3*j +: 3] = 3'b010;
            end
        end
        phase_d = state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_GREEN;
            cur_appr_q <= 2'd0;
            nxt_appr_q <= 2'd0;
            demand_q   <= '0;
            presc_q    <= '0;
            sec_q      <= '0;
            light_q    <= LIGHT_RST;
            phase_q    <= 2'b00;
        end else begin
            state_q    <= state_d;
            cur_appr_q <= cur_appr_d;
            nxt_appr_q <= nxt_appr_d;
            demand_q   <= demand_d;
            presc_q    <= presc_d;
            sec_q      <= sec_d;
            light_q    <= light_d;
            phase_q    <= phase_d;
        end
    end

    assign bus.light    = light_q;
    assign bus.cur_appr = cur_appr_q;
    assign bus.phase    = phase_q;

endmodule
`default_nettype wire

// File: doc/traffic_ctrl_nphase.md
# traffic_ctrl_nphase

Parametrised N-approach, sensor-driven intersection controller; the next generation of the two-road highway/farm light. Approach 0 is the main road and rests green. Side approaches 1..NUM_APPR-1 are served round-robin on latched sensor demand, with programmable minimum, maximum, yellow and optional all-red intervals timed from an internal 1 s tick. It sits at the top of the signal design and drives the lamp drivers directly.

## Interface
- NUM_APPR, 2: number of approaches; legal range 2..4.
- CLK_HZ, 50000000: clk cycles per second (prescaler terminal = CLK_HZ-1).
- GREEN_MIN_S, 10: minimum green in seconds, ≥1.
- GREEN_MAX_S, 20: maximum side-approach green in seconds, ≥GREEN_MIN_S.
- YELLOW_S, 3: yellow interval in seconds, ≥1.
- ALLRED_S, 1: all-red clearance in seconds, ≥1; used only with the macro.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- sense  in  NUM_APPR  per-approach vehicle sensor, level, synchronous to clk; sense[0] ignored.
- light  out  3*NUM_APPR  per-approach lamp, bits [3j+2:3j] = {red,yellow,green}, one-hot: 100 red, 010 yellow, 001 green.
- cur_appr  out  2  approach currently green, or leaving green during yellow.
- phase  out  2  00 green, 01 yellow, 10 all-red.

## Operation
- States: GREEN, YELLOW, ALLRED (ALLRED exists only with the macro). Registers: state, cur_appr, nxt_appr, demand[NUM_APPR-1:1], prescaler, seconds counter sec.
- Tick: the prescaler counts 0..CLK_HZ-1. Tick = prescaler at CLK_HZ-1. On a tick, sec increments. On any state change, the prescaler and sec clear, so every interval is exactly whole seconds.
- Demand: demand[j] sets on any cycle with sense[j]=1, except while j is green. It clears on the edge j enters GREEN.
- GREEN, cur_appr=0: leave at the first tick with sec+1 ≥ GREEN_MIN_S and any demand bit set. With no demand, remain indefinitely.
- GREEN, cur_appr=j>0: leave at the first tick with sec+1 ≥ GREEN_MIN_S and either sense[j]=0 or sec+1 ≥ GREEN_MAX_S.
- On leaving GREEN of i:
  - Select nxt_appr by scanning i+1..NUM_APPR-1 for the first set demand bit.
  - If none is found, select 0.
  - When i=0, scan 1..NUM_APPR-1; at least one bit is set by construction.
  - Enter YELLOW.
- YELLOW: leave at the tick with sec+1 = YELLOW_S. Go to ALLRED, or to GREEN of nxt_appr when the macro is absent.
- ALLRED: all lamps red. Leave at the tick with sec+1 = ALLRED_S to GREEN of nxt_appr; cur_appr ← nxt_appr.
- Lamps: cur_appr is green or yellow per phase; all other approaches are red. Never two approaches non-red at once.

## Timing
- Reset values:
  - state = GREEN, cur_appr = 0, nxt_appr = 0.
  - demand = 0, prescaler = 0, sec = 0.
  - phase = 00.
  - light: approach 0 = 001, others = 100.
- Reset is asynchronous and takes effect immediately mid-interval; on release, main green restarts with the timer at 0.
- light, phase and cur_appr are registered and change on the same edge as state. An interval of K seconds occupies exactly K*CLK_HZ cycles.
- sense is registered into demand first, so a demand asserted on a tick cycle is acted on at the next tick.
- A sensor pulse of one cycle is sufficient to latch demand.

## Configuration
- TRAFFIC_ALLRED_EN defined: a YELLOW→ALLRED→GREEN sequence with ALLRED_S seconds of all-red.
- TRAFFIC_ALLRED_EN undefined: YELLOW→GREEN directly; phase 10 never occurs; ALLRED_S is unused.

## Test plan
All scenarios use NUM_APPR=3, CLK_HZ=10, GREEN_MIN_S=4, GREEN_MAX_S=8, YELLOW_S=2, ALLRED_S=1, with the macro defined unless stated.
- No sensors for 500 cycles after reset → light=100_100_001, phase=00 throughout.
- 1-cycle pulse on sense[1] at cycle 5 → main green ends at cycle 40, yellow for 20 cycles, all-red for 10 cycles, then approach 1 green for 40 cycles (sense low), then yellow/all-red back to main.
- sense[2] held high → approach 2 green for exactly 80 cycles (GREEN_MAX), then return to main. demand[2] re-latches during yellow, so approach 2 is served again after main's 40-cycle minimum.
- sense[1] and sense[2] pulse in the same cycle → served in order 1, 2, 0.
- rst_n asserted mid-yellow → immediate reset values. After release, main green lasts until new demand plus the minimum.
- Macro undefined, with the scenario 2 stimulus → yellow goes directly to approach 1 green after 20 cycles; phase never equals 10.
